// File: rtl/instr_encoder.sv
// Instruction encoder and loader: packs decoded RV32I fields into a word and
// writes it to instruction memory at an auto-incrementing word address.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [6:0]        i_op,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [2:0]        i_funct3,
    input  logic [6:0]        i_funct7,
    input  logic [31:0]       i_imm,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    input  logic              i_imem_ready,
    output logic              o_full,
    output logic              o_err
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    logic              r_out_valid;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic              r_full;
    logic              r_err;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_complete;
    logic        w_sext_ok;
    logic [31:0] w_word;
    logic        w_supported;
    logic        w_range_err;

    assign w_in_ready = !i_clear && !r_full && (!r_out_valid || i_imem_ready);
    assign w_accept   = i_in_valid && w_in_ready;
    assign w_complete = r_out_valid && i_imem_ready;
    assign w_sext_ok  = (i_imm[31:11] == {21{i_imm[11]}});

    // Immediate scatter per format; out-of-range immediates are still packed truncated.
    always_comb begin
        w_word      = '0;
        w_supported = 1'b1;
        w_range_err = 1'b0;
        case (i_op)
            OP_R: begin
                w_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_op};
            end
            OP_LOAD: begin
                w_word      = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_op};
                w_range_err = !w_sext_ok;
            end
            OP_IMM: begin
                if (i_funct3 == 3'b001 || i_funct3 == 3'b101) begin
                    w_word      = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_op};
                    w_range_err = (i_imm[31:5] != 27'd0);
                end else begin
                    w_word      = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_op};
                    w_range_err = !w_sext_ok;
                end
            end
            OP_STORE: begin
                w_word      = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_op};
                w_range_err = !w_sext_ok;
            end
            OP_BRANCH: begin
                w_word      = {i_imm[11], i_imm[9:4], i_rs2, i_rs1, i_funct3,
                               i_imm[3:0], i_imm[10], i_op};
                w_range_err = !w_sext_ok;
            end
            default: begin
                w_supported = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_wdata     <= '0;
            r_addr      <= '0;
            r_full      <= 1'b0;
            r_err       <= 1'b0;
        end else if (i_clear) begin
            r_out_valid <= 1'b0;
            r_wdata     <= '0;
            r_addr      <= '0;
            r_full      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_complete) begin
                if (r_addr == ADDR_MAX) begin
                    r_full <= 1'b1;
                    r_addr <= '0;
                end else begin
                    r_addr <= r_addr + ADDR_ONE;
                end
            end
            // Unsupported opcodes are consumed without touching the output stage.
            if (w_accept && w_supported) begin
                r_out_valid <= 1'b1;
                r_wdata     <= w_word;
            end else if (w_complete) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept && (!w_supported || w_range_err)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_in_ready   = w_in_ready;
    assign o_imem_we    = r_out_valid;
    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = r_wdata;
    assign o_full       = r_full;
    assign o_err        = r_err;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and instruction-memory loader: the inverse of the pipeline's immediate generator and decode path. It accepts decoded instruction fields over a valid/ready handshake and packs them into a 32-bit RV32I word, scattering the immediate into its format-specific bit positions. It writes the word into instruction memory at an auto-incrementing address. It is used by the boot/test loader ahead of the fetch stage, so programs can be built from field-level descriptions.

## Interface
- ADDR_W, 8, word-address width of instruction memory; depth is 2^ADDR_W.
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous restart: address←0, full←0, err←0, pending word discarded.
- in_valid  input  1  field set valid.
- in_ready  output  1  encoder can accept; = !clear && !full && (!out_valid || imem_ready).
- op  input  7  opcode.
- rd, rs1, rs2  input  5 each  register fields.
- funct3  input  3; funct7  input  7.
- imm  input  32  immediate, same value/scaling the immediate generator returns for that format.
- imem_we  output  1  write strobe (= out_valid).
- imem_addr  output  ADDR_W  word address.
- imem_wdata  output  32  encoded word.
- imem_ready  input  1  memory accepts write this cycle.
- full  output  1  last address written; no further accepts until clear.
- err  output  1  sticky error: immediate out of range or unsupported opcode.

## Operation
- Accept when in_valid && in_ready. The encoded word is registered into the output stage (out_valid←1).
- Encoding by op. Field placement: rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20].
  - 0110011 R: {funct7, rs2, rs1, funct3, rd, op}. imm is ignored.
  - 0000011 load, 0010011 OP-IMM: [31:20]=imm[11:0].
  - 0010011 with funct3 001/101 (shifts): [31:25]=funct7, [24:20]=imm[4:0]. Range requires imm[31:5]==0.
  - 0100011 S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - 1100011 B (imm in half-word units, 12 bits): [31]=imm[11], [7]=imm[10], [30:25]=imm[9:4], [11:8]=imm[3:0].
- Range rule for I/S/B: imm[31:11] must be all equal (sign-extension of imm[11:0]).
- Range violation: the word is still written with the truncated immediate, and err is set.
- Any other opcode: accepted, not written (out_valid unchanged), err set.
- Round-trip property: the immediate generator applied to the written word returns imm for every in-range I/S/B input.
- Address counter: increments on each completed write (imem_we && imem_ready).
  - Write at address 2^ADDR_W−1: full←1 and the address wraps to 0.
- clear has priority over everything: in_ready is low during clear, and a simultaneous in_valid is not accepted.

## Timing
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, full=0, err=0; in_ready=1 after reset.
- Latency: one cycle, from the accept edge to imem_we high with valid data.
- Throughput: one word per cycle while imem_ready=1.
- Back-pressure: imem_ready=0 holds imem_we, imem_addr and imem_wdata stable and drops in_ready. In_ready is combinational from imem_ready.
- Accept while the output completes in the same cycle: the output is replaced with the new word and the address advances.
- Reset or clear while out_valid=1: the word is discarded and never written.
- err sets on the clock edge of the offending accept, and clears only on rst or clear.

## Test plan
- Reset then R-type: op=0110011, funct7=0100000, rs2=3, rs1=2, funct3=0, rd=1 (sub x1,x2,x3) -> one cycle later imem_we=1, imem_addr=0, imem_wdata=0x403100B3.
- Round trip: addi imm=−1, sw imm=−4, beq imm=0x7FF and imm=−0x800, streamed back-to-back -> words at addresses 0..3; feeding each through the immediate generator returns imm; err=0.
- Range and unsupported: addi imm=0x800 -> written with [31:20]=0x800, err=1. Then op=1101111 -> no write, address unchanged, err stays 1. clear -> err=0, address 0.
- Back-pressure: imem_ready=0 for 3 cycles mid-stream -> output stable, in_ready=0, no word lost or duplicated; write order and addresses contiguous.
- Full/wrap with ADDR_W=2: 4 writes -> full=1 after the 4th, address=0, in_ready=0. A 5th in_valid is not accepted until clear.
- Async rst asserted mid-cycle with a pending word -> outputs return to reset values immediately; the word is never written.
